// File: rtl/exp_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : exp_share_arbiter
// Description : Round-robin scheduler sharing one pipelined get_exp unit among
//               NUM_REQ requesters; tags each operand and routes results back.
//               Optional statistics counters enabled by macro EXP_ARB_STAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module exp_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 32,
    parameter int EXP_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*DW-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [DW-1:0]         exp_x,
    input  logic [DW-1:0]         exp_y,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]         rsp_data,
    output logic                  busy
`ifdef EXP_ARB_STAT_EN
    ,
    output logic [31:0]           stat_issue,
    output logic [31:0]           stat_conflict
`endif
);

    localparam int              IDXW       = $clog2(NUM_REQ);
    localparam logic [IDXW-1:0] C_LAST_RST = IDXW'(NUM_REQ - 1);

    logic [IDXW-1:0]    last_grant_q, last_grant_d;
    logic [DW-1:0]      exp_x_q, exp_x_d;
    logic [EXP_LAT:0]   tag_vld_q, tag_vld_d;
    logic [IDXW-1:0]    tag_idx_q [EXP_LAT+1];
    logic [IDXW-1:0]    tag_idx_d [EXP_LAT+1];
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]      rsp_data_q, rsp_data_d;

    logic               w_issue;
    logic [IDXW-1:0]    w_gnt_idx;
    logic [DW-1:0]      w_gnt_data;

    // Lowest requester above last_grant wins; otherwise wrap to the lowest one.
    always_comb begin : p_grant
        w_gnt_idx  = '0;
        w_gnt_data = '0;
        req_ready  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (IDXW'(i) <= last_grant_q)) w_gnt_idx = IDXW'(i);
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (IDXW'(i) > last_grant_q)) w_gnt_idx = IDXW'(i);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDXW'(i) == w_gnt_idx) w_gnt_data = req_data[i*DW +: DW];
        end
        w_issue = en && (|req_valid);
        if (w_issue) req_ready[w_gnt_idx] = 1'b1;
    end

    always_comb begin : p_next
        last_grant_d = last_grant_q;
        exp_x_d      = exp_x_q;
        if (w_issue) begin
            last_grant_d = w_gnt_idx;
            exp_x_d      = w_gnt_data;
        end
        // Tag stage k lines up with the operand k cycles into get_exp.
        tag_vld_d    = {tag_vld_q[EXP_LAT-1:0], w_issue};
        tag_idx_d[0] = w_gnt_idx;
        for (int s = 1; s <= EXP_LAT; s++) begin
            tag_idx_d[s] = tag_idx_q[s-1];
        end
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (tag_vld_q[EXP_LAT]) begin
            rsp_valid_d[tag_idx_q[EXP_LAT]] = 1'b1;
            rsp_data_d                      = exp_y;
        end
    end

    always_ff @(posedge clk) begin : p_regs
        if (rst) begin
            last_grant_q <= C_LAST_RST;
            exp_x_q      <= '0;
            tag_vld_q    <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            for (int s = 0; s <= EXP_LAT; s++) begin
                tag_idx_q[s] <= '0;
            end
        end else begin
            last_grant_q <= last_grant_d;
            exp_x_q      <= exp_x_d;
            tag_vld_q    <= tag_vld_d;
            tag_idx_q    <= tag_idx_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign exp_x     = exp_x_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (|tag_vld_q) || (|rsp_valid_q);

`ifdef EXP_ARB_STAT_EN
    logic [31:0] stat_issue_q, stat_issue_d;
    logic [31:0] stat_conflict_q, stat_conflict_d;
    logic        w_multi;

    always_comb begin : p_stat_next
        // More than one bit set: clearing the lowest set bit leaves something.
        w_multi         = (req_valid & (req_valid - 1'b1)) != '0;
        stat_issue_d    = w_issue ? stat_issue_q + 32'd1 : stat_issue_q;
        stat_conflict_d = (en && w_multi) ? stat_conflict_q + 32'd1 : stat_conflict_q;
    end

    always_ff @(posedge clk) begin : p_stat_regs
        if (rst) begin
            stat_issue_q    <= '0;
            stat_conflict_q <= '0;
        end else begin
            stat_issue_q    <= stat_issue_d;
            stat_conflict_q <= stat_conflict_d;
        end
    end

    assign stat_issue    = stat_issue_q;
    assign stat_conflict = stat_conflict_q;
`endif

endmodule
`default_nettype wire

// File: doc/exp_share_arbiter.md
Name: exp_share_arbiter

Overview:
- Round-robin arbiter and scheduler that shares one fully pipelined float32 exponential unit (get_exp) among NUM_REQ requesters, e.g. the softmax lanes.
- Accepts at most one operand per cycle and launches it into the exp pipeline with a requester tag.
- Tracks the tag through the fixed pipeline latency and returns each result to the requester that issued it.
- Sits between the softmax lane controllers and the single get_exp instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DW, 32, operand/result width (IEEE-754 single)
EXP_LAT, 4, fixed get_exp latency in cycles from exp_x stable to exp_y valid (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
en  in  1  grant enable; low = no new grants, in-flight results still drain
req_valid  in  NUM_REQ  per-requester operand valid
req_data  in  NUM_REQ*DW  operands; requester i at bits [i*DW +: DW]
req_ready  out  NUM_REQ  one-hot grant, combinational
exp_x  out  DW  registered operand to get_exp
exp_y  in  DW  result from get_exp
rsp_valid  out  NUM_REQ  one-hot registered result strobe
rsp_data  out  DW  registered result, broadcast to all requesters
busy  out  1  high while any operand is in flight

Behaviour:
- Handshake: an issue occurs in cycle t when req_valid[i] & req_ready[i]. Requesters hold req_data stable while valid and not ready. There is no response backpressure; requesters must sink rsp_valid.
- Grant: req_ready has at most one bit set, and only when en=1. Priority search starts at last_grant+1 (mod NUM_REQ). last_grant updates only on an issue.
- Issue path: on issue in cycle t, exp_x <= req_data[i] at the end of cycle t. A tag pipeline of depth EXP_LAT+1 (valid bit + requester index) shifts every cycle regardless of en.
- Result path: exp_y for that operand is valid in cycle t+1+EXP_LAT. It is captured so that rsp_valid[i]=1 and rsp_data=result in cycle t+2+EXP_LAT. Total latency is EXP_LAT+2.
- Throughput is 1 issue/cycle. Responses return in issue order.
- With no issue, exp_x holds its last value, the tag-valid bit is 0, and rsp_valid is 0 in the corresponding cycle.
- busy = OR of all tag-valid bits and any rsp_valid bit.
- Reset values: exp_x=0, rsp_valid=0, rsp_data=0, all tag-valid bits 0, last_grant=NUM_REQ-1 (requester 0 wins first), busy=0.
- Reset mid-operation: all in-flight operands are discarded. No rsp_valid is produced for them, even though get_exp keeps computing.
- Boundaries:
  - en falling while requests are pending: no grant that cycle; in-flight tags still complete.
  - en rising: the grant resumes from the saved pointer.
  - Single requester asserting continuously: granted every cycle.
  - req_valid dropped without a grant: no side effect.
  - Simultaneous issue and response for the same requester in one cycle: both occur independently.

Optional Feature:
- Macro EXP_ARB_STAT_EN. When defined, two extra outputs are added:
  - stat_issue [31:0]: total issues, wraps at 2^32.
  - stat_conflict [31:0]: cycles with en=1 and more than one req_valid bit set, wraps.
- Both counters are cleared by rst.
- Without the macro, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Bench stub for get_exp: exp_y = exp_x + 1, delayed EXP_LAT=4.
- Single request: req 2 sends 32'h4123AE14 in cycle 10 -> req_ready=4'b0100 in cycle 10; exp_x=32'h4123AE14 in cycle 11; rsp_valid=4'b0100 and rsp_data=32'h4123AE15 in cycle 16; busy high for cycles 11-16.
- All four requesters valid in cycle 0 with operands 0x10, 0x20, 0x30, 0x40, first grant after reset -> grants 0,1,2,3 in cycles 0-3; responses 0x11, 0x21, 0x31, 0x41 on rsp_valid 0001, 0010, 0100, 1000 in cycles 6-9.
- Requesters 0 and 2 held valid for 8 cycles -> grants alternate 0,2,0,2,…; each gets exactly 4 grants.
- en=0 for cycles 5-9 while req 1 is valid -> req_ready=0 during those cycles; in-flight results from cycles 2-4 still return in cycles 8-10; req 1 is granted in cycle 10.
- rst asserted in cycle 3 after issues in cycles 0-2 -> no rsp_valid ever for those issues; exp_x=0, busy=0, and the next grant goes to requester 0.
- EXP_ARB_STAT_EN defined, rerun the four-requester case -> stat_issue=4 and stat_conflict=3 (cycles 0-2).
